// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: NOP encoding, opcode constants and the IF/ID payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_S      = 7'd35;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_BRANCH = 7'd99;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load; a bubble keeps pc/pcPlus4 and clears the instruction.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q.pc      <= '0;
      q.pcPlus4 <= '0;
      q.instr   <= NOP_INSTR;
      q.valid   <= 1'b0;
    end else if (bubble) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, redirect/stall/wait priority, IF/ID register and stall/flush counters.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcWrite,
  input  logic             IF_ID_Write,
  input  logic             branchTaken,
  input  logic [31:0]      branchTarget,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      pc_ID,
  output logic [31:0]      pcPlus4_ID,
  output logic [31:0]      instr_ID,
  output logic             valid_ID,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic        ifid_load;
  logic        ifid_bubble;
  logic        stall_inc;
  logic        flush_inc;
  if_id_t      ifid_d;
  if_id_t      ifid_q;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Priority: redirect, then hazard stall, then memory wait, then normal fetch.
  always_comb begin
    pc_next     = pc;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (branchTaken) begin
      pc_next     = {branchTarget[31:2], 2'b00};
      ifid_bubble = 1'b1;
      flush_inc   = 1'b1;
    end else if (!pcWrite || !IF_ID_Write) begin
      if (pcWrite && imem_ready) pc_next = pc_plus4;
      if (IF_ID_Write) ifid_bubble = 1'b1;
      stall_inc = !pcWrite && !IF_ID_Write;
    end else if (!imem_ready) begin
      ifid_bubble = 1'b1;
    end else begin
      pc_next   = pc_plus4;
      ifid_load = 1'b1;
    end
  end

  always_comb begin
    ifid_d.pc      = pc;
    ifid_d.pcPlus4 = pc_plus4;
    ifid_d.instr   = imem_rdata;
    ifid_d.valid   = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

  // Performance counters saturate rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stall_inc && stallCount != CNT_MAX) stallCount <= stallCount + CNT_W'(1);
      if (flush_inc && flushCount != CNT_MAX) flushCount <= flushCount + CNT_W'(1);
    end
  end

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign pc_ID      = ifid_q.pc;
  assign pcPlus4_ID = ifid_q.pcPlus4;
  assign instr_ID   = ifid_q.instr;
  assign valid_ID   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a combinational instruction memory model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcWrite, IF_ID_Write, branchTaken, imem_ready;
  logic [31:0] branchTarget, imem_addr, imem_rdata;
  logic [31:0] pc_ID, pcPlus4_ID, instr_ID;
  logic        valid_ID;
  logic [3:0]  stallCount, flushCount;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.RESET_PC(32'h0000_0100), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .pcWrite      (pcWrite),
    .IF_ID_Write  (IF_ID_Write),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .pc_ID        (pc_ID),
    .pcPlus4_ID   (pcPlus4_ID),
    .instr_ID     (instr_ID),
    .valid_ID     (valid_ID),
    .stallCount   (stallCount),
    .flushCount   (flushCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    if (a == 32'h104) return 32'h00A0_0113;
    return a ^ 32'h5A5A_0013;
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic        pw, iw, bt, rdy;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_pc_id, e_instr;
    logic        e_valid;
    logic [3:0]  e_stall, e_flush;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic pw, iw, bt, rdy, input logic [31:0] tgt,
                              input logic [31:0] e_pc, e_pc_id, e_instr, input logic e_valid,
                              input logic [3:0] e_stall, e_flush);
    vec_t v;
    v.pw = pw; v.iw = iw; v.bt = bt; v.rdy = rdy; v.tgt = tgt;
    v.e_pc = e_pc; v.e_pc_id = e_pc_id; v.e_instr = e_instr; v.e_valid = e_valid;
    v.e_stall = e_stall; v.e_flush = e_flush;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pw, iw, bt, rdy, input logic [31:0] tgt);
    pcWrite = pw; IF_ID_Write = iw; branchTaken = bt; imem_ready = rdy; branchTarget = tgt;
  endtask

  initial begin
    // pw iw bt rdy tgt | pc, pc_ID, instr, valid, stall, flush
    vecs[0]  = mk(1,1,0,1, 0,            32'h104, 32'h100, 32'h0050_0093, 1, 0, 0);
    vecs[1]  = mk(1,1,0,1, 0,            32'h108, 32'h104, 32'h00A0_0113, 1, 0, 0);
    vecs[2]  = mk(0,0,0,1, 0,            32'h108, 32'h104, 32'h00A0_0113, 1, 1, 0);
    vecs[3]  = mk(1,1,0,1, 0,            32'h10C, 32'h108, mem_word(32'h108), 1, 1, 0);
    vecs[4]  = mk(0,0,1,1, 32'h200,      32'h200, 32'h108, NOP, 0, 1, 1);
    vecs[5]  = mk(1,1,0,1, 0,            32'h204, 32'h200, mem_word(32'h200), 1, 1, 1);
    vecs[6]  = mk(1,1,1,0, 32'h203,      32'h200, 32'h200, NOP, 0, 1, 2);
    vecs[7]  = mk(1,1,1,1, 32'h40,       32'h040, 32'h200, NOP, 0, 1, 3);
    vecs[8]  = mk(1,1,0,0, 0,            32'h040, 32'h200, NOP, 0, 1, 3);
    vecs[9]  = mk(1,1,0,0, 0,            32'h040, 32'h200, NOP, 0, 1, 3);
    vecs[10] = mk(1,1,0,0, 0,            32'h040, 32'h200, NOP, 0, 1, 3);
    vecs[11] = mk(1,1,0,1, 0,            32'h044, 32'h040, mem_word(32'h40), 1, 1, 3);
    vecs[12] = mk(1,0,0,1, 0,            32'h048, 32'h040, mem_word(32'h40), 1, 1, 3);
    vecs[13] = mk(1,0,0,0, 0,            32'h048, 32'h040, mem_word(32'h40), 1, 1, 3);
    vecs[14] = mk(0,1,0,1, 0,            32'h048, 32'h040, NOP, 0, 1, 3);
    vecs[15] = mk(1,1,1,1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h040, NOP, 0, 1, 4);
    vecs[16] = mk(1,1,0,1, 0,            32'h000, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 1, 1, 4);

    reset = 1'b1;
    drive(1, 1, 0, 1, 0);
    #12;
    chk("rst_pc",      imem_addr, 32'h100);
    chk("rst_instr",   instr_ID, NOP);
    chk("rst_valid",   32'(valid_ID), 0);
    chk("rst_pc_id",   pc_ID, 0);
    chk("rst_pc4_id",  pcPlus4_ID, 0);
    chk("rst_stall",   32'(stallCount), 0);
    chk("rst_flush",   32'(flushCount), 0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].pw, vecs[i].iw, vecs[i].bt, vecs[i].rdy, vecs[i].tgt);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i),    imem_addr, vecs[i].e_pc);
      chk($sformatf("v%0d_pc_id", i), pc_ID, vecs[i].e_pc_id);
      chk($sformatf("v%0d_pc4", i),   pcPlus4_ID, vecs[i].e_pc_id + 32'd4);
      chk($sformatf("v%0d_instr", i), instr_ID, vecs[i].e_instr);
      chk($sformatf("v%0d_valid", i), 32'(valid_ID), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_stall", i), 32'(stallCount), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_flush", i), 32'(flushCount), 32'(vecs[i].e_flush));
    end

    // Long stall: 4-bit counter saturates at 15.
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d", k), 32'(stallCount), (k + 2 > 15) ? 32'd15 : 32'(k + 2));
    end
    chk("sat_pc_hold", imem_addr, 32'h0);

    // Async reset mid-stall with a redirect pending.
    drive(1, 1, 1, 1, 32'h300);
    @(posedge clk);
    #1;
    chk("ar_pc", imem_addr, 32'h300);
    drive(0, 0, 1, 1, 32'h500);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_pc_rst",  imem_addr, 32'h100);
    chk("ar_valid",   32'(valid_ID), 0);
    chk("ar_instr",   instr_ID, NOP);
    chk("ar_stall",   32'(stallCount), 0);
    chk("ar_flush",   32'(flushCount), 0);
    drive(1, 1, 0, 1, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_resume_pc_id", pc_ID, 32'h100);
    chk("ar_resume_instr", instr_ID, 32'h0050_0093);
    chk("ar_resume_pc",    imem_addr, 32'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
